// File: rtl/caxi4interconnect_pack_pkg.sv
// Shared helpers for the width-upsizing pack FIFO: sizing functions and entry layout.
package caxi4interconnect_pack_pkg;

  localparam int DEF_DATA_WIDTH_IN = 32;
  localparam int DEF_RATIO         = 4;
  localparam int DEF_MEM_DEPTH     = 16;
  localparam int MAX_RATIO         = 16;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Stored entry is {last, mask[ratio], data[ratio*dwi]}, last in the MSB.
  function automatic int entry_width(input int dwi, input int ratio);
    return 1 + ratio + dwi * ratio;
  endfunction

endpackage

// File: rtl/caxi4interconnect_pack_fifo_ctrl.sv
// Pointer, level and flag bookkeeping for the pack FIFO; all flags registered from the next level.
module caxi4interconnect_pack_fifo_ctrl #(
  parameter int DEPTH   = 16,
  parameter int PTR_W   = 4,
  parameter int LEVEL_W = 5,
  parameter int NF      = 12,
  parameter int NE      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               commit,
  input  logic               pop,
  output logic [PTR_W-1:0]   wr_ptr,
  output logic [PTR_W-1:0]   rd_ptr,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty,
  output logic               nearly_full,
  output logic               nearly_empty,
  output logic               one_from_full
);

  logic [LEVEL_W-1:0] level_nxt;

  always_comb begin
    level_nxt = level;
    if (clr)                 level_nxt = '0;
    else if (commit && !pop) level_nxt = level + LEVEL_W'(1);
    else if (pop && !commit) level_nxt = level - LEVEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      nearly_full   <= 1'b0;
      nearly_empty  <= 1'b1;
      one_from_full <= 1'b0;
    end else begin
      // Pointers wrap naturally; occupancy is judged from level alone.
      if (clr)         wr_ptr <= '0;
      else if (commit) wr_ptr <= wr_ptr + PTR_W'(1);
      if (clr)         rd_ptr <= '0;
      else if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      level         <= level_nxt;
      full          <= (level_nxt == LEVEL_W'(DEPTH));
      empty         <= (level_nxt == '0);
      nearly_full   <= (int'(level_nxt) >= NF);
      nearly_empty  <= (int'(level_nxt) <= NE);
      one_from_full <= (level_nxt == LEVEL_W'(DEPTH - 1));
    end
  end

endmodule

// File: rtl/caxi4interconnect_pack_fifo.sv
// Width-upsizing FIFO: packs RATIO narrow beats into one wide word, early commit on wr_last.
module caxi4interconnect_pack_fifo
  import caxi4interconnect_pack_pkg::*;
#(
  parameter int DATA_WIDTH_IN       = DEF_DATA_WIDTH_IN,
  parameter int RATIO               = DEF_RATIO,
  parameter int MEM_DEPTH           = DEF_MEM_DEPTH,
  parameter int NEARLY_FULL_THRESH  = 12,
  parameter int NEARLY_EMPTY_THRESH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [DATA_WIDTH_IN-1:0]             wr_data,
  input  logic                                 wr_last,
  output logic                                 rd_valid,
  input  logic                                 rd_ready,
  output logic [RATIO*DATA_WIDTH_IN-1:0]       rd_data,
  output logic [RATIO-1:0]                     rd_lane_mask,
  output logic                                 rd_last,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic                                 fifo_nearly_full,
  output logic                                 fifo_nearly_empty,
  output logic                                 fifo_one_from_full,
  output logic [$clog2((MEM_DEPTH < 2) ? 2 : MEM_DEPTH):0] fifo_level
);

  localparam int DEPTH          = (MEM_DEPTH < 2) ? 2 : MEM_DEPTH;
  localparam int DATA_WIDTH_OUT = RATIO * DATA_WIDTH_IN;
  localparam int LEVEL_WIDTH    = $clog2(DEPTH) + 1;
  localparam int PTR_W          = clog2_min1(DEPTH);
  localparam int LANE_W         = clog2_min1(RATIO);
  localparam int ENTRY_W        = entry_width(DATA_WIDTH_IN, RATIO);

  logic [LANE_W-1:0]                        lane_cnt;
  logic [RATIO-1:0][DATA_WIDTH_IN-1:0]      stage_data, commit_data;
  logic [RATIO-1:0]                         stage_mask, commit_mask;
  logic [ENTRY_W-1:0]                       mem [DEPTH];
  logic [PTR_W-1:0]                         wr_ptr, rd_ptr;
  logic [DATA_WIDTH_OUT-1:0]                head_data;
  logic [RATIO-1:0]                         head_mask;
  logic                                     head_last;
  logic                                     accept, close, commit, pop;

  assign wr_ready = !fifo_full;
  assign rd_valid = !fifo_empty;
  assign accept   = wr_valid && wr_ready && !clr;
  assign close    = (lane_cnt == LANE_W'(RATIO - 1)) || wr_last;
  assign commit   = accept && close;
  assign pop      = rd_valid && rd_ready && !clr;

  // Staged lanes below L, the current beat at L, zeros above.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign commit_data[k] = (lane_cnt == LANE_W'(k)) ? wr_data :
                            (lane_cnt >  LANE_W'(k)) ? stage_data[k] : '0;
  end
  assign commit_mask = stage_mask | (RATIO'(1) << lane_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt   <= '0;
      stage_mask <= '0;
      stage_data <= '0;
    end else if (clr) begin
      lane_cnt   <= '0;
      stage_mask <= '0;
    end else if (accept) begin
      if (close) begin
        lane_cnt   <= '0;
        stage_mask <= '0;
      end else begin
        lane_cnt   <= lane_cnt + LANE_W'(1);
        stage_mask <= commit_mask;
        stage_data <= commit_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[wr_ptr] <= {wr_last, commit_mask, commit_data};
    end
  end

  // Head entry falls through; blanked when nothing is stored so clr looks like reset.
  assign {head_last, head_mask, head_data} = mem[rd_ptr];
  assign rd_data      = rd_valid ? head_data : '0;
  assign rd_lane_mask = rd_valid ? head_mask : '0;
  assign rd_last      = rd_valid && head_last;

  caxi4interconnect_pack_fifo_ctrl #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .LEVEL_W (LEVEL_WIDTH),
    .NF      (NEARLY_FULL_THRESH),
    .NE      (NEARLY_EMPTY_THRESH)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .commit        (commit),
    .pop           (pop),
    .wr_ptr        (wr_ptr),
    .rd_ptr        (rd_ptr),
    .level         (fifo_level),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .nearly_full   (fifo_nearly_full),
    .nearly_empty  (fifo_nearly_empty),
    .one_from_full (fifo_one_from_full)
  );

  a_no_accept_full: assert property (@(posedge clk) disable iff (!rst)
    !(wr_valid && wr_ready && fifo_full));
  a_level_max: assert property (@(posedge clk) disable iff (!rst)
    int'(fifo_level) <= DEPTH);
  a_nf_thresh: assert property (@(posedge clk) disable iff (!rst)
    NEARLY_FULL_THRESH <= DEPTH);
  a_ratio_rng: assert property (@(posedge clk) disable iff (!rst)
    (RATIO >= 1) && (RATIO <= MAX_RATIO));

endmodule

// File: tb/tb_caxi4interconnect_pack_fifo.sv
// Scoreboard bench for the pack FIFO (RATIO=4 main instance plus a RATIO=1 instance).
module tb_caxi4interconnect_pack_fifo;

  typedef struct packed {
    logic         last;
    logic [3:0]   mask;
    logic [127:0] data;
  } word_t;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic wr_valid = 1'b0, wr_last = 1'b0, rd_ready = 1'b0;
  logic [31:0] wr_data = '0;
  logic wr_ready, rd_valid, rd_last, fifo_full, fifo_empty;
  logic fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full;
  logic [127:0] rd_data;
  logic [3:0]   rd_lane_mask;
  logic [4:0]   fifo_level;

  logic wr_valid1 = 1'b0, wr_last1 = 1'b0, rd_ready1 = 1'b0;
  logic [31:0] wr_data1 = '0;
  logic wr_ready1, rd_valid1, rd_last1, full1, empty1, nf1, ne1, oaf1;
  logic [31:0] rd_data1;
  logic [0:0]  rd_mask1;
  logic [4:0]  level1;

  int tests = 0, fails = 0;
  bit wdone = 1'b0;
  word_t sb[$];
  logic [32:0] sb1[$];

  always #5 clk = ~clk;

  caxi4interconnect_pack_fifo dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_lane_mask(rd_lane_mask), .rd_last(rd_last),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_nearly_full(fifo_nearly_full),
    .fifo_nearly_empty(fifo_nearly_empty), .fifo_one_from_full(fifo_one_from_full),
    .fifo_level(fifo_level)
  );

  caxi4interconnect_pack_fifo #(.RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_data(wr_data1), .wr_last(wr_last1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1),
    .rd_lane_mask(rd_mask1), .rd_last(rd_last1),
    .fifo_full(full1), .fifo_empty(empty1), .fifo_nearly_full(nf1),
    .fifo_nearly_empty(ne1), .fifo_one_from_full(oaf1), .fifo_level(level1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare the head word against the scoreboard whenever it is popped.
  always @(negedge clk) begin
    word_t e;
    if (rst && rd_valid && rd_ready && !clr) begin
      if (sb.size() == 0) chk("sb_unexpected_word", rd_data, 128'hx);
      else begin
        e = sb.pop_front();
        chk("sb_data", rd_data, e.data);
        chk("sb_mask", 128'(rd_lane_mask), 128'(e.mask));
        chk("sb_last", 128'(rd_last), 128'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e1;
    if (rst && rd_valid1 && rd_ready1 && !clr) begin
      if (sb1.size() == 0) chk("sb1_unexpected_word", 128'(rd_data1), 128'hx);
      else begin
        e1 = sb1.pop_front();
        chk("sb1_data", 128'(rd_data1), 128'(e1[31:0]));
        chk("sb1_mask", 128'(rd_mask1), 128'(1));
        chk("sb1_last", 128'(rd_last1), 128'(e1[32]));
      end
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic last);
    int n = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    @(negedge clk);
    while (!wr_ready && n < 200) begin n++; @(negedge clk); end
    if (!wr_ready) chk("push_timeout_wr_ready", 128'(wr_ready), 128'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    @(negedge clk);
    while (!fifo_empty && n < 500) begin n++; @(negedge clk); end
    chk({name, "_drained"}, 128'(fifo_empty), 128'(1));
    chk({name, "_sb_left"}, 128'(sb.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  function automatic word_t full_word(input logic [31:0] base);
    word_t w;
    w.last = 1'b0; w.mask = 4'hF;
    for (int k = 0; k < 4; k++) w.data[32*k +: 32] = base + 32'(k);
    return w;
  endfunction

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wr_ready"}, 128'(wr_ready), 128'(1));
    chk({name, "_rd_valid"}, 128'(rd_valid), 128'(0));
    chk({name, "_mask"}, 128'(rd_lane_mask), 128'(0));
    chk({name, "_last"}, 128'(rd_last), 128'(0));
    chk({name, "_data"}, rd_data, 128'(0));
    chk({name, "_empty"}, 128'(fifo_empty), 128'(1));
    chk({name, "_nearly_empty"}, 128'(fifo_nearly_empty), 128'(1));
    chk({name, "_full"}, 128'(fifo_full), 128'(0));
    chk({name, "_nearly_full"}, 128'(fifo_nearly_full), 128'(0));
    chk({name, "_one_from_full"}, 128'(fifo_one_from_full), 128'(0));
    chk({name, "_level"}, 128'(fifo_level), 128'(0));
  endtask

  initial begin
    int lvl;
    int n;
    #12;
    chk_reset_outputs("reset");
    chk("reset_r1_level", 128'(level1), 128'(0));
    chk("reset_r1_wr_ready", 128'(wr_ready1), 128'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Two full words streamed straight through.
    rd_ready = 1'b1;
    sb.push_back('{1'b0, 4'hF, 128'h00000044_00000033_00000022_00000011});
    sb.push_back('{1'b0, 4'hF, 128'h00000088_00000077_00000066_00000055});
    for (int i = 0; i < 8; i++) push_beat(32'(i + 1) * 32'h11, 1'b0);
    wait_empty("full_words");
    rd_ready = 1'b0;

    // Partial word closed by wr_last.
    sb.push_back('{1'b1, 4'h3, 128'h00000000_00000000_0000000B_0000000A});
    push_beat(32'hA, 1'b0);
    push_beat(32'hB, 1'b1);
    @(negedge clk);
    chk("partial_level_1", 128'(fifo_level), 128'(1));
    chk("partial_rd_valid", 128'(rd_valid), 128'(1));
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(negedge clk);
    chk("partial_level_0", 128'(fifo_level), 128'(0));
    @(posedge clk); #1;

    // Fill to full with one beat per cycle; beats offered while full must be dropped.
    for (int j = 0; j < 16; j++) sb.push_back(full_word(32'h100 + 32'(4 * j)));
    for (int i = 0; i < 68; i++) begin
      wr_valid = 1'b1; wr_data = 32'h100 + 32'(i); wr_last = 1'b0;
      @(negedge clk);
      lvl = (i < 64) ? i / 4 : 16;
      chk("fill_level", 128'(fifo_level), 128'(lvl));
      chk("fill_full", 128'(fifo_full), 128'(lvl == 16));
      chk("fill_one_from_full", 128'(fifo_one_from_full), 128'(lvl == 15));
      chk("fill_nearly_full", 128'(fifo_nearly_full), 128'(lvl >= 12));
      chk("fill_nearly_empty", 128'(fifo_nearly_empty), 128'(lvl <= 2));
      chk("fill_wr_ready", 128'(wr_ready), 128'(lvl != 16));
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(negedge clk);
    chk("pop_from_full_level", 128'(fifo_level), 128'(15));
    chk("pop_from_full_wr_ready", 128'(wr_ready), 128'(1));
    chk("pop_from_full_oaf", 128'(fifo_one_from_full), 128'(1));
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_empty("fill");
    rd_ready = 1'b0;

    // Commit and pop on the same edge at level 5.
    for (int j = 0; j < 6; j++) sb.push_back(full_word(32'h200 + 32'(4 * j)));
    for (int i = 0; i < 23; i++) push_beat(32'h200 + 32'(i), 1'b0);
    wr_valid = 1'b1; wr_data = 32'h200 + 32'd23; rd_ready = 1'b1;
    @(negedge clk);
    chk("simul_level_before", 128'(fifo_level), 128'(5));
    @(posedge clk); #1 wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("simul_level_after", 128'(fifo_level), 128'(5));
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_empty("simul");
    rd_ready = 1'b0;

    // 128 beats across several pointer wraps with random read stalls.
    fork
      begin
        for (int j = 0; j < 32; j++) begin
          sb.push_back(full_word(32'hC000_0000 + 32'(4 * j)));
          for (int k = 0; k < 4; k++) begin
            push_beat(32'hC000_0000 + 32'(4 * j + k), 1'b0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
        end
        wdone = 1'b1;
      end
      begin
        n = 0;
        while (!(wdone && sb.size() == 0) && n < 3000) begin
          @(posedge clk); #1 rd_ready = 1'($urandom_range(0, 1));
          n++;
        end
        rd_ready = 1'b0;
        if (n >= 3000) chk("wrap_timeout_sb_left", 128'(sb.size()), 128'(0));
      end
    join
    @(negedge clk);
    chk("wrap_empty", 128'(fifo_empty), 128'(1));
    @(posedge clk); #1;

    // clr with 3 words stored and two lanes staged; same-cycle beat and pop ignored.
    for (int i = 0; i < 14; i++) push_beat(32'h300 + 32'(i), 1'b0);
    clr = 1'b1; wr_valid = 1'b1; wr_data = 32'hDEAD; rd_ready = 1'b1;
    @(posedge clk); #1 clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk_reset_outputs("clr");
    @(posedge clk); #1;
    sb.push_back(full_word(32'h401));
    for (int i = 1; i <= 4; i++) push_beat(32'h400 + 32'(i), 1'b0);
    @(negedge clk);
    chk("clr_fresh_level", 128'(fifo_level), 128'(1));
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_empty("clr");
    rd_ready = 1'b0;

    // Async reset with two words stored and a partial word staged.
    for (int i = 0; i < 10; i++) push_beat(32'h500 + 32'(i), 1'b0);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back(full_word(32'h601));
    for (int i = 1; i <= 4; i++) push_beat(32'h600 + 32'(i), 1'b0);
    rd_ready = 1'b1;
    wait_empty("post_reset");
    rd_ready = 1'b0;

    // RATIO=1 instance: plain FIFO behaviour.
    sb1.push_back({1'b0, 32'hA1});
    sb1.push_back({1'b0, 32'hA2});
    sb1.push_back({1'b1, 32'hA3});
    for (int i = 0; i < 3; i++) begin
      wr_valid1 = 1'b1; wr_data1 = 32'hA1 + 32'(i); wr_last1 = (i == 2);
      @(negedge clk);
      chk("r1_level_during", 128'(level1), 128'(i));
      @(posedge clk); #1;
    end
    wr_valid1 = 1'b0; wr_last1 = 1'b0;
    @(negedge clk);
    chk("r1_level_3", 128'(level1), 128'(3));
    @(posedge clk); #1 rd_ready1 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!empty1 && n < 100) begin n++; @(negedge clk); end
    chk("r1_drained", 128'(empty1), 128'(1));
    chk("r1_sb_left", 128'(sb1.size()), 128'(0));
    rd_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
